// File: rtl/an_sec_serial_decoder.sv
// Bit-serial single-error-correcting AN code decoder: residue by shift/subtract, error search by doubling mod A.
// Optional AN_SEC_STATS_EN adds saturating corrected/uncorrectable result counters.
module an_sec_serial_decoder #(
    parameter int unsigned CW_W = 19,
    parameter int unsigned A    = 1939,
    parameter int unsigned R_W  = 11,
    parameter int unsigned L_W  = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CW_W-1:0] in_cw,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW_W-1:0] out_cw,
    output logic [L_W-1:0]  out_loc,
    output logic            out_err,
    output logic            out_uncorr
`ifdef AN_SEC_STATS_EN
   ,output logic [15:0]     stat_corr,
    output logic [15:0]     stat_uncorr
`endif
);

    localparam int unsigned C_W = $clog2(CW_W + 1);
    localparam logic [R_W:0]   A_X = (R_W+1)'(A);
    localparam logic [R_W-1:0] A_R = R_W'(A);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REM  = 2'd1,
        SRCH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW_W-1:0] cw_q, cw_d;
    logic [CW_W-1:0] sr_q, sr_d;
    logic [C_W-1:0]  cnt_q, cnt_d;
    logic [R_W-1:0]  rem_q, rem_d;
    logic [R_W-1:0]  p_q, p_d;
    logic [CW_W-1:0] mask_q, mask_d;
    logic [L_W-1:0]  k_q, k_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [CW_W-1:0] out_cw_q, out_cw_d;
    logic [L_W-1:0]  out_loc_q, out_loc_d;
    logic            out_err_q, out_err_d;
    logic            out_uncorr_q, out_uncorr_d;

    logic [R_W:0]    rem_ext, p_ext;
    logic [R_W-1:0]  rem_nxt, p_nxt;

    // Shift-in and doubling steps, each reduced by a single conditional subtract of A
    always_comb begin
        rem_ext = {rem_q, sr_q[CW_W-1]};
        rem_nxt = (rem_ext >= A_X) ? R_W'(rem_ext - A_X) : R_W'(rem_ext);
        p_ext   = {p_q, 1'b0};
        p_nxt   = (p_ext >= A_X) ? R_W'(p_ext - A_X) : R_W'(p_ext);
    end

    always_comb begin
        state_d      = state_q;
        cw_d         = cw_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        rem_d        = rem_q;
        p_d          = p_q;
        mask_d       = mask_q;
        k_d          = k_q;
        out_valid_d  = out_valid_q;
        out_cw_d     = out_cw_q;
        out_loc_d    = out_loc_q;
        out_err_d    = out_err_q;
        out_uncorr_d = out_uncorr_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cw_d    = in_cw;
                    sr_d    = in_cw;
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = REM;
                end
            end
            REM: begin
                rem_d = rem_nxt;
                sr_d  = {sr_q[CW_W-2:0], 1'b0};
                cnt_d = cnt_q + C_W'(1);
                if (cnt_q == C_W'(CW_W - 1)) begin
                    if (rem_nxt == '0) begin
                        state_d      = DONE;
                        out_cw_d     = cw_q;
                        out_loc_d    = '0;
                        out_err_d    = 1'b0;
                        out_uncorr_d = 1'b0;
                    end else begin
                        state_d = SRCH;
                        p_d     = R_W'(1);
                        k_d     = L_W'(1);
                        mask_d  = CW_W'(1);
                    end
                end
            end
            SRCH: begin
                // p tracks 2^(k-1) mod A; A odd means both compares never hit together
                if (p_q == rem_q) begin
                    state_d      = DONE;
                    out_cw_d     = cw_q - mask_q;
                    out_loc_d    = k_q;
                    out_err_d    = 1'b1;
                    out_uncorr_d = 1'b0;
                end else if (p_q == (A_R - rem_q)) begin
                    state_d      = DONE;
                    out_cw_d     = cw_q + mask_q;
                    out_loc_d    = L_W'(0) - k_q;
                    out_err_d    = 1'b1;
                    out_uncorr_d = 1'b0;
                end else if (k_q == L_W'(CW_W)) begin
                    state_d      = DONE;
                    out_cw_d     = cw_q;
                    out_loc_d    = '0;
                    out_err_d    = 1'b1;
                    out_uncorr_d = 1'b1;
                end else begin
                    p_d    = p_nxt;
                    k_d    = k_q + L_W'(1);
                    mask_d = {mask_q[CW_W-2:0], 1'b0};
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cw_q         <= '0;
            sr_q         <= '0;
            cnt_q        <= '0;
            rem_q        <= '0;
            p_q          <= '0;
            mask_q       <= '0;
            k_q          <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_cw_q     <= '0;
            out_loc_q    <= '0;
            out_err_q    <= 1'b0;
            out_uncorr_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cw_q         <= cw_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            rem_q        <= rem_d;
            p_q          <= p_d;
            mask_q       <= mask_d;
            k_q          <= k_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_cw_q     <= out_cw_d;
            out_loc_q    <= out_loc_d;
            out_err_q    <= out_err_d;
            out_uncorr_q <= out_uncorr_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_cw     = out_cw_q;
    assign out_loc    = out_loc_q;
    assign out_err    = out_err_q;
    assign out_uncorr = out_uncorr_q;

`ifdef AN_SEC_STATS_EN
    logic        hs;
    logic [15:0] stat_corr_q, stat_corr_d;
    logic [15:0] stat_uncorr_q, stat_uncorr_d;

    // Count each result class once, on the cycle the consumer takes it
    always_comb begin
        hs            = (state_q == DONE) && out_valid_q && out_ready;
        stat_corr_d   = stat_corr_q;
        stat_uncorr_d = stat_uncorr_q;
        if (hs && out_uncorr_q && (stat_uncorr_q != 16'hFFFF)) begin
            stat_uncorr_d = stat_uncorr_q + 16'd1;
        end
        if (hs && out_err_q && !out_uncorr_q && (stat_corr_q != 16'hFFFF)) begin
            stat_corr_d = stat_corr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_corr_q   <= '0;
            stat_uncorr_q <= '0;
        end else begin
            stat_corr_q   <= stat_corr_d;
            stat_uncorr_q <= stat_uncorr_d;
        end
    end

    assign stat_corr   = stat_corr_q;
    assign stat_uncorr = stat_uncorr_q;
`endif

endmodule
